// File: rtl/g_ser4tx.sv
// g_ser4tx: 4-bit parallel-in, serial-out framed transmitter.
// Frame is start, 4 data bits LSB first, optional parity, stop.
module g_ser4tx #(
    parameter int DIV = 1,
    parameter int PAR = 0
) (
    input  logic       CK,
    input  logic       RN,
    input  logic       LD,
    input  logic [3:0] D,
    output logic       SO,
    output logic       RDY,
    output logic       BUSY,
    output logic       DONE
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CMAX = CW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    bcnt, bcnt_n;
    logic [3:0]    shreg, shreg_n;
    logic          pbit, pbit_n;
    logic          so_n, rdy_n, done_n;
    logic          tick;

    assign tick = (cnt == CMAX);

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state <= IDLE;
            cnt   <= '0;
            bcnt  <= '0;
            shreg <= '0;
            pbit  <= 1'b0;
            SO    <= 1'b1;
            RDY   <= 1'b1;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            bcnt  <= bcnt_n;
            shreg <= shreg_n;
            pbit  <= pbit_n;
            SO    <= so_n;
            RDY   <= rdy_n;
            BUSY  <= ~rdy_n;
            DONE  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        bcnt_n  = bcnt;
        shreg_n = shreg;
        pbit_n  = pbit;
        done_n  = 1'b0;
        if (state == IDLE || tick) begin
            cnt_n = '0;
        end else begin
            cnt_n = cnt + 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (LD) begin
                    shreg_n = D;
                    pbit_n  = (PAR == 2) ? ~^D : ^D;
                    bcnt_n  = 2'd0;
                    state_n = START;
                end
            end
            START: begin
                if (tick) state_n = DATA;
            end
            DATA: begin
                if (tick) begin
                    if (bcnt == 2'd3) begin
                        state_n = (PAR != 0) ? PARITY : STOP;
                    end else begin
                        shreg_n = {1'b0, shreg[3:1]};
                        bcnt_n  = bcnt + 2'd1;
                    end
                end
            end
            PARITY: begin
                if (tick) state_n = STOP;
            end
            STOP: begin
                if (tick) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are registered, so they follow the state being entered.
        unique case (state_n)
            START:   so_n = 1'b0;
            DATA:    so_n = shreg_n[0];
            PARITY:  so_n = pbit_n;
            default: so_n = 1'b1;
        endcase
        rdy_n = (state_n == IDLE);
    end

endmodule

// File: tb/tb_g_ser4tx.sv
// Bench for g_ser4tx: four parameterisations, scoreboard of
// expected per-cycle line/handshake values, sampled on negedge.
module tb_g_ser4tx;

    logic       CK = 1'b0;
    logic       RN = 1'b0;
    logic [3:0] ld = 4'h0;
    logic [3:0] d [4];
    logic [3:0] so, rdy, busy, done;

    int checks = 0;
    int errors = 0;

    always #5 CK = ~CK;

    g_ser4tx #(.DIV(1), .PAR(0)) u0 (
        .CK(CK), .RN(RN), .LD(ld[0]), .D(d[0]),
        .SO(so[0]), .RDY(rdy[0]), .BUSY(busy[0]), .DONE(done[0])
    );
    g_ser4tx #(.DIV(3), .PAR(2)) u1 (
        .CK(CK), .RN(RN), .LD(ld[1]), .D(d[1]),
        .SO(so[1]), .RDY(rdy[1]), .BUSY(busy[1]), .DONE(done[1])
    );
    g_ser4tx #(.DIV(3), .PAR(1)) u2 (
        .CK(CK), .RN(RN), .LD(ld[2]), .D(d[2]),
        .SO(so[2]), .RDY(rdy[2]), .BUSY(busy[2]), .DONE(done[2])
    );
    g_ser4tx #(.DIV(2), .PAR(1)) u3 (
        .CK(CK), .RN(RN), .LD(ld[3]), .D(d[3]),
        .SO(so[3]), .RDY(rdy[3]), .BUSY(busy[3]), .DONE(done[3])
    );

    typedef struct {
        logic  so;
        logic  rdy;
        logic  done;
        string tag;
    } exp_t;

    typedef struct {
        int         k;
        logic [3:0] data;
        logic       pbit;
        string      tag;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[8];

    function automatic int div_of(input int k);
        case (k)
            0: return 1;
            1: return 3;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int par_of(input int k);
        case (k)
            0: return 0;
            1: return 2;
            default: return 1;
        endcase
    endfunction

    task automatic push_n(input int n, input logic s, input logic r,
                          input logic dn, input string tag);
        exp_t e;
        e.so = s;
        e.rdy = r;
        e.done = dn;
        e.tag = tag;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic push_frame(input int k, input logic [3:0] data,
                              input logic pbit, input bit tail,
                              input string tag);
        int dv;
        dv = div_of(k);
        push_n(dv, 1'b0, 1'b0, 1'b0, {tag, "_start"});
        for (int i = 0; i < 4; i++)
            push_n(dv, data[i], 1'b0, 1'b0, {tag, "_data"});
        if (par_of(k) != 0) push_n(dv, pbit, 1'b0, 1'b0, {tag, "_par"});
        push_n(dv, 1'b1, 1'b0, 1'b0, {tag, "_stop"});
        push_n(1, 1'b1, 1'b1, 1'b1, {tag, "_done"});
        if (tail) push_n(1, 1'b1, 1'b1, 1'b0, {tag, "_idle"});
    endtask

    task automatic check_pop(input int k);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty inst%0d", k);
            return;
        end
        e = sb.pop_front();
        if (so[k] !== e.so || rdy[k] !== e.rdy ||
            done[k] !== e.done || busy[k] !== ~e.rdy) begin
            errors++;
            $display("FAIL %s inst%0d got so=%b rdy=%b busy=%b done=%b want so=%b rdy=%b busy=%b done=%b",
                     e.tag, k, so[k], rdy[k], busy[k], done[k],
                     e.so, e.rdy, ~e.rdy, e.done);
        end
    endtask

    task automatic check_idle(input int k, input string tag);
        checks++;
        if (so[k] !== 1'b1 || rdy[k] !== 1'b1 ||
            busy[k] !== 1'b0 || done[k] !== 1'b0) begin
            errors++;
            $display("FAIL %s inst%0d got so=%b rdy=%b busy=%b done=%b want so=1 rdy=1 busy=0 done=0",
                     tag, k, so[k], rdy[k], busy[k], done[k]);
        end
    endtask

    // Called at a negedge; LD is pulsed once, D is scrambled
    // afterwards and a stray LD is raised while busy.
    task automatic run_frame(input int k, input logic [3:0] data,
                             input logic pbit, input string tag);
        int j;
        ld[k] = 1'b1;
        d[k] = data;
        push_frame(k, data, pbit, 1'b1, tag);
        j = 0;
        while (sb.size() > 0 && j < 200) begin
            @(negedge CK);
            j++;
            check_pop(k);
            if (j == 1) begin
                ld[k] = 1'b0;
                d[k] = ~data;
            end
            if (j == 3) begin
                ld[k] = 1'b1;
                d[k] = 4'hF;
            end
            if (j == 4) ld[k] = 1'b0;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout left=%0d want 0", tag, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) d[i] = 4'h0;
        tbl[0] = '{0, 4'b1110, 1'b0, "basic"};
        tbl[1] = '{1, 4'b1011, 1'b0, "odd_1011"};
        tbl[2] = '{2, 4'b1011, 1'b1, "even_1011"};
        tbl[3] = '{0, 4'h9, 1'b0, "basic_9"};
        tbl[4] = '{1, 4'h0, 1'b1, "odd_0"};
        tbl[5] = '{2, 4'h7, 1'b1, "even_7"};
        tbl[6] = '{3, 4'hC, 1'b0, "div2_C"};
        tbl[7] = '{3, 4'hE, 1'b1, "div2_E"};

        // Reset held: LD toggling must not start anything.
        repeat (5) begin
            @(negedge CK);
            for (int k = 0; k < 4; k++) check_idle(k, "rst_hold");
            ld = 4'($urandom);
            for (int k = 0; k < 4; k++) d[k] = 4'($urandom);
        end
        @(negedge CK);
        ld = 4'h0;
        RN = 1'b1;
        repeat (5) begin
            @(negedge CK);
            for (int k = 0; k < 4; k++) check_idle(k, "post_rst");
        end

        for (int i = 0; i < 8; i++)
            run_frame(tbl[i].k, tbl[i].data, tbl[i].pbit, tbl[i].tag);

        // Back-to-back: LD held through the DONE cycle.
        ld[0] = 1'b1;
        d[0] = 4'h5;
        push_frame(0, 4'h5, 1'b0, 1'b0, "b2b_5");
        push_frame(0, 4'hA, 1'b0, 1'b1, "b2b_A");
        for (int j = 1; j <= 15; j++) begin
            @(negedge CK);
            check_pop(0);
            if (j == 2) d[0] = 4'hF;
            if (j == 6) d[0] = 4'hA;
            if (j == 8) begin
                d[0] = 4'hF;
                ld[0] = 1'b0;
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_left got %0d want 0", sb.size());
            sb.delete();
        end

        // Asynchronous reset during data bit 2 of a DIV=2 frame.
        @(negedge CK);
        ld[3] = 1'b1;
        d[3] = 4'h9;
        push_frame(3, 4'h9, 1'b0, 1'b0, "abort");
        for (int j = 1; j <= 7; j++) begin
            @(negedge CK);
            check_pop(3);
            if (j == 1) ld[3] = 1'b0;
        end
        #2;
        RN = 1'b0;
        #1;
        check_idle(3, "async_rst");
        sb.delete();
        @(negedge CK);
        check_idle(3, "rst_low");
        RN = 1'b1;
        repeat (4) begin
            @(negedge CK);
            check_idle(3, "no_done");
        end
        run_frame(3, 4'h3, 1'b0, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/g_ser4tx.md
# g_ser4tx

Schematic-capture behavioural macro: 4-bit parallel-in, serial-out framed transmitter. Accepts a nibble through a load/ready handshake and shifts it onto a single line as start bit, 4 data bits LSB first, optional parity bit and stop bit. It is the sending end for the library's gate-level pattern-decode terms (e.g. 4-input match terms on a deserialised nibble). It is used wherever a schematic needs a compact, clock-divided serial source.

## Interface

- DIV, 1, clock cycles per bit time; legal range 1..256; counter width = max(1, ceil(log2(DIV))).
- PAR, 0, parity mode: 0 = none, 1 = even, 2 = odd; other values are illegal and are not checked.

- CK  input  1  rising-edge clock; the only clock in the block.
- RN  input  1  reset, asynchronous, active-low.
- LD  input  1  load request; a word is accepted on a rising CK edge when LD=1 and RDY=1.
- D   input  4  data nibble; sampled only on the accepting edge.
- SO  output 1  serial line; idle high.
- RDY output 1  ready to accept a load.
- BUSY output 1  frame in progress; always equal to ~RDY.
- DONE output 1  one-cycle pulse marking frame completion.

## Operation

- All outputs are registered. RN=0 forces SO=1, RDY=1, BUSY=0 and DONE=0, with state IDLE, bit counter 0 and divider 0, immediately and without waiting for CK.
- States are IDLE, START, DATA, PARITY and STOP.
  - IDLE: SO=1, RDY=1. If LD=1, D is latched into the shift register, the parity bit is computed from the latched bits, and the state moves to START.
  - START: SO=0 for DIV cycles, then DATA.
  - DATA: SO=shreg[0]; the register shifts right once per bit time. After 4 bit times the state moves to PARITY if PAR≠0, otherwise to STOP.
  - PARITY: SO=^D_latched for PAR=1, or ~^D_latched for PAR=2. It lasts one bit time, then STOP.
  - STOP: SO=1 for one bit time, then IDLE.
- The divider counts 0..DIV-1 in every non-IDLE state. The bit boundary is at count DIV-1, where the divider wraps to 0. With DIV=1 the divider is constant and every cycle is a boundary.
- LD while RDY=0 is ignored: D is not captured and no error is flagged.
- Changes on D after the accepting edge have no effect on the frame in progress.
- DONE=1 for exactly one cycle, the first IDLE cycle after STOP. During that cycle RDY=1 and SO=1.
- Back-to-back loads: LD held high during the DONE cycle is accepted. The minimum idle gap on SO is 1 cycle.
- Reset mid-frame aborts the frame. There is no DONE pulse and no partial stop bit. SO returns to 1 asynchronously.
- Release of RN takes effect on the first CK edge with RN=1. The first accept can happen on that edge.

## Timing

- Frame length N = 6 bit times for PAR=0, or 7 for PAR≠0. Each bit time is exactly DIV cycles.
- Accepting edge E0: after E0, SO=0, RDY=0 and BUSY=1.
- The start bit occupies cycles E0+1 .. E0+DIV. Data bit i occupies cycles E0+(i+1)·DIV+1 .. E0+(i+2)·DIV.
- RDY returns high, with DONE=1, in cycle E0+N·DIV+1. The next accept edge can be at E0+N·DIV+1.
- The minimum frame period is N·DIV+1 cycles.
- The latency from the accepting edge to the first start-bit cycle is 1 cycle.

## Test plan

- Reset check: hold RN=0 and toggle CK and LD. Required: SO=1, RDY=1, BUSY=0, DONE=0 throughout. Then release RN, wait 5 cycles, and confirm there is no activity.
- Basic frame: DIV=1, PAR=0, D=4'b1110, LD pulsed for 1 cycle. Required: SO over the cycles after the accept = 0,0,1,1,1,1. Then DONE=1 with SO=1, RDY low for exactly 6 cycles, BUSY=~RDY at all times.
- Parity and divider: DIV=3, PAR=2, D=4'b1011. Required: each bit held 3 cycles, sequence start 0, then 1,1,0,1, parity 0 (odd), stop 1. RDY low for 21 cycles. Repeat with PAR=1 and confirm parity=1.
- Back-to-back and ignore: DIV=1, PAR=0, LD held high with D=4'h5 then 4'hA. Change D to 4'hF mid-frame. Required: frames carry 5 then A, F is never sent, 1-cycle SO=1 gap coincides with DONE, frame period 7 cycles.
- Reset mid-operation: DIV=2, PAR=1. Assert RN during data bit 2, asynchronously between edges. Required: SO=1 and RDY=1 before the next CK edge, no DONE pulse. A subsequent load of 4'h3 transmits a clean full frame.
